// File: rtl/multi_mode_counter_if.sv
// Control/data bundle for multi_mode_counter: step/load controls in, code and terminal count out.
// Master drives the controls; the counter (slave) returns Count and the combinational Tc.
interface multi_mode_counter_if #(
  parameter int W = 4
);
  logic         En;
  logic         Up;
  logic         M;
  logic         Load;
  logic [W-1:0] D;
  logic [W-1:0] Count;
  logic         Tc;

  modport master (
    output En, Up, M, Load, D,
    input  Count, Tc
  );

  modport slave (
    input  En, Up, M, Load, D,
    output Count, Tc
  );
endinterface

// File: rtl/multi_mode_counter.sv
// Up/down counter stepping in binary or reflected-Gray order on the falling clock edge.
// One falling edge from Load/En sample to new Count; Tc is combinational; no backpressure.
module multi_mode_counter #(
  parameter int W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  multi_mode_counter_if.slave bus
);

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] GRAY_TOP = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] bin_cur;
  logic [W-1:0] bin_step;
  logic [W-1:0] gray_next;
  logic [W-1:0] bin_next;
  logic [W-1:0] step_val;
  logic         terminal;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_cur = '0;
    for (int i = 0; i < W; i++) begin
      bin_cur[i] = ^(count_q >> i);
    end
  end

  assign bin_step  = bus.Up ? (bin_cur + ONE) : (bin_cur - ONE);
  assign gray_next = bin_step ^ (bin_step >> 1);
  assign bin_next  = bus.Up ? (count_q + ONE) : (count_q - ONE);
  assign step_val  = bus.M ? gray_next : bin_next;

  always_comb begin
    count_d = count_q;
    if (bus.Load) begin
      count_d = bus.D;
    end else if (bus.En) begin
      count_d = step_val;
    end
  end

  // The wrap point in Gray-up is gray(2^W-1), i.e. MSB set and all lower bits clear.
  always_comb begin
    terminal = 1'b0;
    case ({bus.M, bus.Up})
      2'b01:   terminal = &count_q;
      2'b11:   terminal = (count_q == GRAY_TOP);
      default: terminal = (count_q == '0);
    endcase
  end

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.Count = count_q;
  assign bus.Tc    = bus.En & ~bus.Load & terminal;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Bench for multi_mode_counter (W=3): directed vector table, async reset sequence,
// then random stimulus against an index-based reference model.
module tb_multi_mode_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multi_mode_counter_if #(.W(3)) bus ();

  multi_mode_counter #(.W(3)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       en;
    logic       up;
    logic       m;
    logic [2:0] d;
    logic       exp_tc;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, en, up, m, input logic [2:0] d,
                     input logic exp_tc, input logic [2:0] exp_cnt);
    vec_t v;
    v = '{ld, en, up, m, d, exp_tc, exp_cnt};
    vecs.push_back(v);
  endtask

  task automatic apply(input logic ld, en, up, m, input logic [2:0] d);
    bus.Load = ld;
    bus.En   = en;
    bus.Up   = up;
    bus.M    = m;
    bus.D    = d;
  endtask

  // Reference model: position of a code in its sequence, stepped by plain modular arithmetic.
  function automatic logic [2:0] gray_of(input int i);
    return 3'(i ^ (i >> 1));
  endfunction

  function automatic int gidx(input logic [2:0] c);
    for (int i = 0; i < 8; i++) begin
      if (gray_of(i) == c) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_next(input logic [2:0] c, input logic ld, en, up, m,
                                            input logic [2:0] d);
    int delta;
    delta = up ? 1 : 7;
    if (ld) return d;
    if (!en) return c;
    if (!m) return 3'((int'(c) + delta) % 8);
    return gray_of((gidx(c) + delta) % 8);
  endfunction

  function automatic logic model_tc(input logic [2:0] c, input logic ld, en, up, m);
    int idx;
    idx = m ? gidx(c) : int'(c);
    if (!en || ld) return 1'b0;
    return up ? (idx == 7) : (idx == 0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] m_cnt;
    logic [2:0] prev;
    logic       r_rst, r_ld, r_en, r_up, r_m;
    logic [2:0] r_d;

    checks = 0;
    errors = 0;

    // Binary up, 9 edges
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 3'd0, (i == 8), 3'(i % 8));
    add(1, 1, 1, 0, 3'd0, 0, 3'b000);
    // Gray up
    add(0, 1, 1, 1, 3'd0, 0, 3'b001);
    add(0, 1, 1, 1, 3'd0, 0, 3'b011);
    add(0, 1, 1, 1, 3'd0, 0, 3'b010);
    add(0, 1, 1, 1, 3'd0, 0, 3'b110);
    add(0, 1, 1, 1, 3'd0, 0, 3'b111);
    add(0, 1, 1, 1, 3'd0, 0, 3'b101);
    add(0, 1, 1, 1, 3'd0, 0, 3'b100);
    add(0, 1, 1, 1, 3'd0, 1, 3'b000);
    // Gray down
    add(0, 1, 0, 1, 3'd0, 1, 3'b100);
    add(0, 1, 0, 1, 3'd0, 0, 3'b101);
    add(0, 1, 0, 1, 3'd0, 0, 3'b111);
    add(0, 1, 0, 1, 3'd0, 0, 3'b110);
    add(0, 1, 0, 1, 3'd0, 0, 3'b010);
    add(0, 1, 0, 1, 3'd0, 0, 3'b011);
    add(0, 1, 0, 1, 3'd0, 0, 3'b001);
    add(0, 1, 0, 1, 3'd0, 0, 3'b000);
    // Mode switch: binary to 011, Gray step, binary step
    add(0, 1, 1, 0, 3'd0, 0, 3'b001);
    add(0, 1, 1, 0, 3'd0, 0, 3'b010);
    add(0, 1, 1, 0, 3'd0, 0, 3'b011);
    add(0, 1, 1, 1, 3'd0, 0, 3'b010);
    add(0, 1, 1, 0, 3'd0, 0, 3'b011);
    // Load priority, with Tc masked by Load at a would-be wrap (count 0, down)
    add(1, 0, 0, 0, 3'd0, 0, 3'b000);
    add(1, 1, 0, 0, 3'b101, 0, 3'b101);
    add(0, 0, 0, 0, 3'd0, 0, 3'b101);
    add(0, 0, 0, 0, 3'd0, 0, 3'b101);
    add(0, 0, 0, 0, 3'd0, 0, 3'b101);
    add(1, 0, 1, 0, 3'b110, 0, 3'b110);

    rst = 1'b1;
    apply(0, 0, 1, 0, 3'd0);
    #1;
    chk("reset_count", bus.Count, 3'b000);
    chk("reset_tc", bus.Tc, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[k]) begin
      apply(vecs[k].ld, vecs[k].en, vecs[k].up, vecs[k].m, vecs[k].d);
      #1;
      chk($sformatf("vec%0d_tc", k), bus.Tc, vecs[k].exp_tc);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_count", k), bus.Count, vecs[k].exp_cnt);
    end

    // Asynchronous reset between edges at Count=110
    apply(0, 1, 1, 0, 3'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_count", bus.Count, 3'b000);
    chk("async_rst_tc_up", bus.Tc, 1'b0);
    bus.Up = 1'b0;
    #1;
    chk("async_rst_tc_down", bus.Tc, 1'b1);
    apply(1, 1, 1, 0, 3'b111);
    @(negedge clk);
    #1;
    chk("rst_ignores_load", bus.Count, 3'b000);
    @(posedge clk);
    rst = 1'b0;
    apply(0, 1, 1, 0, 3'd0);
    @(negedge clk);
    #1;
    chk("rst_release_step", bus.Count, 3'b001);

    m_cnt = 3'b001;
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 31) == 0);
      r_ld  = ($urandom_range(0, 7) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_up  = 1'($urandom_range(0, 1));
      r_m   = 1'($urandom_range(0, 1));
      r_d   = 3'($urandom_range(0, 7));
      apply(r_ld, r_en, r_up, r_m, r_d);
      rst = r_rst;
      if (r_rst) m_cnt = 3'b000;
      #1;
      chk("rnd_pre_count", bus.Count, m_cnt);
      chk("rnd_tc", bus.Tc, model_tc(m_cnt, r_ld, r_en, r_up, r_m));
      prev = m_cnt;
      @(negedge clk);
      #1;
      if (!r_rst) m_cnt = model_next(m_cnt, r_ld, r_en, r_up, r_m, r_d);
      chk("rnd_count", bus.Count, m_cnt);
      if (!r_rst && r_en && !r_ld && r_m) begin
        chk("rnd_gray_hamming", $countones(bus.Count ^ prev), 1);
      end
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
